// File: rtl/ysyx_22050243_pkg.sv
// Shared decode types for the ID stage: opcodes, control bundle layout,
// field encodings, exception flags and the stage state machine.
package ysyx_22050243_pkg;

  localparam int CTRL_BITS = 14;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    M2R_ALU   = 3'd0,
    M2R_MEM   = 3'd1,
    M2R_IMM   = 3'd2,
    M2R_PC4   = 3'd3,
    M2R_PCIMM = 3'd4,
    M2R_CSR   = 3'd5
  } mem2reg_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_JAL  = 2'd1,
    PC_JALR = 2'd2
  } pc_src_e;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'd0,
    ALU_BRANCH  = 3'd1,
    ALU_OP      = 3'd2,
    ALU_OPIMM   = 3'd3,
    ALU_OP32    = 3'd6,
    ALU_OPIMM32 = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic     csr_r;
    logic     alu_src;
    mem2reg_e mem2reg;
    logic     reg_w;
    logic     mem_r;
    logic     mem_w;
    logic     branch;
    pc_src_e  pc_src;
    alu_op_e  alu_op;
  } ctrl_t;

  typedef struct packed {
    logic illegal;
    logic ecall;
    logic ebreak;
  } exc_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_22050243_inst_dec.sv
// Combinational RV32I/RV64I decoder: instruction word to control bundle and
// exception flags. Anything not recognised yields illegal with a zero bundle.
module ysyx_22050243_inst_dec
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output exc_t        exc
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [11:0] imm12_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign imm12_s  = inst[31:20];

  // Field decode; every path starts from an all-zero bundle.
  always_comb begin
    ctrl = '0;
    exc  = '0;
    if (inst[1:0] != 2'b11) begin
      exc.illegal = 1'b1;
    end else begin
      case (opcode_s)
        OPC_LUI:    begin ctrl.mem2reg = M2R_IMM;   ctrl.reg_w = 1'b1; end
        OPC_AUIPC:  begin ctrl.mem2reg = M2R_PCIMM; ctrl.reg_w = 1'b1; end
        OPC_JAL:    begin ctrl.mem2reg = M2R_PC4; ctrl.reg_w = 1'b1; ctrl.pc_src = PC_JAL;  end
        OPC_JALR:   begin ctrl.mem2reg = M2R_PC4; ctrl.reg_w = 1'b1; ctrl.pc_src = PC_JALR; end
        OPC_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_BRANCH; end
        OPC_LOAD: begin
          ctrl.alu_src = 1'b1;
          ctrl.mem2reg = M2R_MEM;
          ctrl.reg_w   = 1'b1;
          ctrl.mem_r   = 1'b1;
        end
        OPC_STORE:  begin ctrl.alu_src = 1'b1; ctrl.mem_w = 1'b1; end
        OPC_OP_IMM: begin ctrl.alu_src = 1'b1; ctrl.reg_w = 1'b1; ctrl.alu_op = ALU_OPIMM; end
        OPC_OP:     begin ctrl.reg_w = 1'b1; ctrl.alu_op = ALU_OP; end
        OPC_OP_IMM32: begin
          if (RV64) begin
            ctrl.alu_src = 1'b1;
            ctrl.reg_w   = 1'b1;
            ctrl.alu_op  = ALU_OPIMM32;
          end else begin
            exc.illegal = 1'b1;
          end
        end
        OPC_OP_32: begin
          if (RV64) begin
            ctrl.reg_w  = 1'b1;
            ctrl.alu_op = ALU_OP32;
          end else begin
            exc.illegal = 1'b1;
          end
        end
        OPC_FENCE: begin
          ctrl = '0;
        end
        OPC_SYSTEM: begin
          case (funct3_s)
            3'b000: begin
              if (imm12_s == 12'h000) begin
                exc.ecall = 1'b1;
              end else if (imm12_s == 12'h001) begin
                exc.ebreak = 1'b1;
              end else begin
                exc.illegal = 1'b1;
              end
            end
            3'b100: exc.illegal = 1'b1;
            default: begin
              ctrl.csr_r   = 1'b1;
              ctrl.mem2reg = M2R_CSR;
              ctrl.reg_w   = 1'b1;
            end
          endcase
        end
        default: exc.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050243_decode_stage.sv
// Registered ID stage: decodes on the input side, holds entries in an output
// register plus a one-entry skid buffer, and sequences the ebreak halt.
module ysyx_22050243_decode_stage
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PC_W   = 64,
  parameter int CTRL_W = CTRL_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [2:0]        out_exc,
  output logic              halted
);

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
    exc_t            exc;
  } entry_t;

  ctrl_t  dec_ctrl_s;
  exc_t   dec_exc_s;
  entry_t in_entry_s;
  entry_t out_r;
  entry_t skid_r;
  logic   out_valid_r;
  logic   skid_valid_r;
  logic   halted_r;
  state_e state_r;
  state_e state_nxt_s;
  logic   in_ready_s;
  logic   accept_s;
  logic   leave_s;
  logic   flush_s;

  ysyx_22050243_inst_dec #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .ctrl (dec_ctrl_s),
    .exc  (dec_exc_s)
  );

  assign in_entry_s = '{inst: in_inst, pc: in_pc, ctrl: dec_ctrl_s, exc: dec_exc_s};
  assign in_ready_s = !rst && (state_r == ST_RUN) && !skid_valid_r;
  assign accept_s   = in_valid && in_ready_s;
  assign leave_s    = out_valid_r && out_ready;
  // Once halted the stage is frozen, so redirect flushes no longer apply.
  assign flush_s    = flush && (state_r != ST_HALTED);

  // Halt sequencing; a flushed ebreak never arms the halt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && !flush && dec_exc_s.ebreak) begin
          state_nxt_s = ST_HALT_PEND;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT_PEND: begin
        if (flush_s) begin
          state_nxt_s = ST_RUN;
        end else if (leave_s && out_r.exc.ebreak) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_HALT_PEND;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // State and halted flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == ST_HALTED);
    end
  end

  // Output register and skid buffer; skid always holds the younger entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush_s) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (leave_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_r <= in_entry_s;
      end
      out_valid_r <= skid_valid_r || accept_s;
    end else if (accept_s) begin
      if (out_valid_r) begin
        skid_r       <= in_entry_s;
        skid_valid_r <= 1'b1;
      end else begin
        out_r       <= in_entry_s;
        out_valid_r <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_inst  = out_r.inst;
  assign out_pc    = out_r.pc;
  assign out_ctrl  = out_r.ctrl;
  assign out_exc   = out_r.exc;
  assign halted    = halted_r;

endmodule

// File: tb/tb_ysyx_22050243_decode_stage.sv
// Directed bench for the decode stage with a FIFO scoreboard of expected
// entries and an independent reference decode table.
module tb_ysyx_22050243_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, halted;
  logic [31:0] in_inst, out_inst;
  logic [63:0] in_pc, out_pc;
  logic [13:0] out_ctrl;
  logic [2:0]  out_exc;
  logic [31:0] w32;
  logic [13:0] c32;
  logic [2:0]  e32;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [16:0] de;
  } sb_t;
  sb_t sb_q[$];

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22050243_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_exc(out_exc), .halted(halted)
  );

  ysyx_22050243_inst_dec #(.XLEN(32)) u_dec32 (.inst(w32), .ctrl(c32), .exc(e32));

  // Reference decode: {ctrl[13:0], exc[2:0]}
  function automatic logic [16:0] ref_dec(logic [31:0] w, bit x64);
    logic [13:0] c;
    logic [2:0]  e;
    c = 14'd0;
    e = 3'b000;
    if (w[1:0] != 2'b11) e = 3'b100;
    else begin
      case (w[6:0])
        7'h37: c = 14'b0_0_010_1_0_0_0_00_000;
        7'h17: c = 14'b0_0_100_1_0_0_0_00_000;
        7'h6F: c = 14'b0_0_011_1_0_0_0_01_000;
        7'h67: c = 14'b0_0_011_1_0_0_0_10_000;
        7'h63: c = 14'b0_0_000_0_0_0_1_00_001;
        7'h03: c = 14'b0_1_001_1_1_0_0_00_000;
        7'h23: c = 14'b0_1_000_0_0_1_0_00_000;
        7'h13: c = 14'b0_1_000_1_0_0_0_00_011;
        7'h33: c = 14'b0_0_000_1_0_0_0_00_010;
        7'h1B: if (x64) c = 14'b0_1_000_1_0_0_0_00_111; else e = 3'b100;
        7'h3B: if (x64) c = 14'b0_0_000_1_0_0_0_00_110; else e = 3'b100;
        7'h0F: c = 14'd0;
        7'h73: begin
          if (w[14:12] == 3'b000) begin
            if (w[31:20] == 12'h000) e = 3'b010;
            else if (w[31:20] == 12'h001) e = 3'b001;
            else e = 3'b100;
          end else if (w[14:12] == 3'b100) e = 3'b100;
          else c = 14'b1_0_101_1_0_0_0_00_000;
        end
        default: e = 3'b100;
      endcase
    end
    return {c, e};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(logic [31:0] w, logic [63:0] p);
    in_valid = 1'b1;
    in_inst  = w;
    in_pc    = p;
  endtask

  // Score this cycle's handshakes, then advance to the next falling edge.
  task automatic tick();
    sb_t e;
    #1;
    if (rst) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", {32'd0, out_inst}, 64'hDEAD);
        else begin
          e = sb_q.pop_front();
          chk("sb_inst", {32'd0, out_inst}, {32'd0, e.inst});
          chk("sb_pc", out_pc, e.pc);
          chk("sb_ctrl", {50'd0, out_ctrl}, {50'd0, e.de[16:3]});
          chk("sb_exc", {61'd0, out_exc}, {61'd0, e.de[2:0]});
        end
      end
      if (flush && !halted) sb_q.delete();
      else if (in_valid && in_ready) begin
        e.inst = in_inst;
        e.pc   = in_pc;
        e.de   = ref_dec(in_inst, 1'b1);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] words [12] = '{32'h123452B7, 32'h00001317, 32'h008000EF, 32'h00008067,
                             32'h00112223, 32'h0FF0000F, 32'h00004073, 32'h00200073,
                             32'h00000002, 32'h0000007F, 32'h0010009B, 32'h002081BB};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 64'd0;
    flush = 1'b0; out_ready = 1'b0; w32 = 32'd0;
    tick(); tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_ctrl", {50'd0, out_ctrl}, 64'd0);
    chk("rst_out_exc", {61'd0, out_exc}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // 1: streaming at full throughput
    out_ready = 1'b1;
    offer(32'h00500093, 64'h1000); tick();
    chk("t1_valid0", {63'd0, out_valid}, 64'd1);
    chk("t1_addi_ctrl", {50'd0, out_ctrl}, {50'd0, 14'b0_1_000_1_0_0_0_00_011});
    offer(32'h0000A103, 64'h1004); tick();
    chk("t1_valid1", {63'd0, out_valid}, 64'd1);
    chk("t1_lw_ctrl", {50'd0, out_ctrl}, {50'd0, 14'b0_1_001_1_1_0_0_00_000});
    offer(32'h00208463, 64'h1008); tick();
    chk("t1_valid2", {63'd0, out_valid}, 64'd1);
    chk("t1_beq_ctrl", {50'd0, out_ctrl}, {50'd0, 14'b0_0_000_0_0_0_1_00_001});
    in_valid = 1'b0; tick();
    chk("t1_drained", {63'd0, out_valid}, 64'd0);

    // 2: backpressure fills out + skid
    out_ready = 1'b0;
    offer(32'h002081B3, 64'h2000); tick();
    offer(32'h40208233, 64'h2004); tick();
    offer(32'h00308293, 64'h2008); #1;
    chk("t2_full_in_ready", {63'd0, in_ready}, 64'd0);
    tick(); tick();
    chk("t2_stable_inst", {32'd0, out_inst}, 64'h002081B3);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("t2_empty", {63'd0, out_valid}, 64'd0);
    chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 4: decode corner cases
    offer(32'h00000000, 64'h3000); tick();
    chk("t4_zero_exc", {61'd0, out_exc}, 64'b100);
    offer(32'h00000073, 64'h3004); tick();
    chk("t4_ecall_exc", {61'd0, out_exc}, 64'b010);
    offer(32'h30529073, 64'h3008); tick();
    chk("t4_csrrw_ctrl", {50'd0, out_ctrl}, {50'd0, 14'b1_0_101_1_0_0_0_00_000});
    for (int i = 0; i < 12; i++) begin
      offer(words[i], 64'h3100 + 64'(4 * i)); tick();
    end
    in_valid = 1'b0; tick(); tick();
    chk("t4_sb_empty", 64'(sb_q.size()), 64'd0);
    w32 = 32'h0010009B; #1;
    chk("t4_x32_addiw_exc", {61'd0, e32}, 64'b100);
    chk("t4_x32_addiw_ctrl", {50'd0, c32}, 64'd0);
    w32 = 32'h002081BB; #1;
    chk("t4_x32_addw_exc", {61'd0, e32}, 64'b100);

    // 5: flush with out + skid full, then flush against a live accept
    out_ready = 1'b0;
    offer(32'h00100113, 64'h4000); tick();
    offer(32'h00200193, 64'h4004); tick();
    offer(32'h00300213, 64'h4008); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("t5_flush_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_flush_in_ready", {63'd0, in_ready}, 64'd1);
    offer(32'h00400293, 64'h400C); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("t5_flush_wins", {63'd0, out_valid}, 64'd0);
    tick(); tick();
    chk("t5_nothing_out", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    offer(32'h00100073, 64'h4010); tick();
    in_valid = 1'b0; #1;
    chk("t5_pend_in_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_pend_flushed_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_pend_flushed_halt", {63'd0, halted}, 64'd0);

    // 6: reset during HALT_PEND with two entries held
    offer(32'h00500093, 64'h5000); tick();
    offer(32'h00100073, 64'h5004); tick();
    in_valid = 1'b0;
    chk("t6_pend_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1; tick();
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_inst", {32'd0, out_inst}, 64'd0);
    chk("t6_pc", out_pc, 64'd0);
    chk("t6_ctrl", {50'd0, out_ctrl}, 64'd0);
    chk("t6_exc", {61'd0, out_exc}, 64'd0);
    chk("t6_halted", {63'd0, halted}, 64'd0);
    rst = 1'b0; #1;
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);

    // 3: ebreak then addi; stage halts and ignores input
    out_ready = 1'b1;
    offer(32'h00100073, 64'h6000); tick();
    offer(32'h00500093, 64'h6004); #1;
    chk("t3_block", {63'd0, in_ready}, 64'd0);
    tick();
    chk("t3_halted", {63'd0, halted}, 64'd1);
    chk("t3_out_valid", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_frozen_ready", {63'd0, in_ready}, 64'd0);
      chk("t3_frozen_valid", {63'd0, out_valid}, 64'd0);
    end
    chk("t3_still_halted", {63'd0, halted}, 64'd1);
    chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_decode_stage.md
Name: ysyx_22050243_decode_stage

Overview:
Registered instruction-decode stage sitting between the IF fetch buffer and the EX stage.
- Decodes the RV32I/RV64I opcode, funct3 and imm12 fields into the 14-bit control bundle plus exception flags.
- Carries each decoded entry on a valid/ready handshake through an output register backed by a one-entry skid buffer.
- Sequences a clean stop: an accepted ebreak blocks further accepts until that entry retires, after which `halted` is asserted.
- Supports pipeline flush from the redirect logic.

Parameters:
XLEN, 64, datapath width; 64 enables OP_IMM32/OP_32 decode, 32 makes them illegal.
PC_W, 64, program counter width.
CTRL_W, 14, control bundle width (fixed by package, exposed for ports).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage can accept this cycle.
in_inst  in  32  instruction word.
in_pc  in  PC_W  PC of in_inst.
flush  in  1  discard all held entries.
out_valid  out  1  decoded entry available.
out_ready  in  1  EX accepts the entry.
out_inst  out  32  registered instruction.
out_pc  out  PC_W  registered PC.
out_ctrl  out  CTRL_W  {csr_r, alu_src, mem2reg[2:0], reg_w, mem_r, mem_w, branch, pc_src[1:0], alu_op[2:0]}.
out_exc  out  3  {illegal, ecall, ebreak}.
halted  out  1  ebreak has retired; stage is frozen.

Behaviour:
Reset:
- out_valid=0, out_inst=0, out_pc=0, out_ctrl=0, out_exc=0, halted=0.
- Skid empty; state=RUN.
- in_ready=1 from the first cycle after rst deasserts; in_ready=0 while rst=1.

Decode (combinational on in_inst):
- LUI 0_0_010_1_0_0_0_00_000; AUIPC 0_0_100_1_0_0_0_00_000.
- JAL 0_0_011_1_0_0_0_01_000; JALR 0_0_011_1_0_0_0_10_000.
- BRANCH 0_0_000_0_0_0_1_00_001; LOAD 0_1_001_1_1_0_0_00_000; STORE 0_1_000_0_0_1_0_00_000.
- OP_IMM ..._011; OP ..._010; OP_IMM32 ..._111; OP_32 ..._110; FENCE all-zero bundle.
- SYSTEM, funct3≠000 and ≠100: CSR bundle 1_0_101_1_0_0_0_00_000.
- SYSTEM, funct3=000: imm12=0x000 → ecall; 0x001 → ebreak; both with a zero bundle.
- illegal=1, bundle zero, for any of:
  - inst[1:0]≠11;
  - unknown opcode;
  - all-zero word;
  - SYSTEM funct3=100;
  - SYSTEM funct3=000 with any other imm12;
  - OP_IMM32/OP_32 when XLEN=32.

Handshake:
- Accept occurs when in_valid & in_ready. Entry appears on out_* the next cycle (latency 1).
- An entry leaves when out_valid & out_ready.
- in_ready = (state==RUN) & !skid_valid.
- If an accept occurs while the out register holds an entry that is not leaving, the new entry goes to skid.
- When out leaves: skid (if valid) moves to out; otherwise an entry accepted that cycle moves to out.
- Order is strictly FIFO. Never drop or duplicate an entry.
- out_* is stable while out_valid & !out_ready.
- Full-throughput: back-to-back accepts with out_ready=1 give one entry per cycle.

State machine (RUN, HALT_PEND, HALTED):
- RUN→HALT_PEND: an accepted entry has ebreak=1. in_ready drops the next cycle; any skid entry ahead of it still drains.
- HALT_PEND→HALTED: the ebreak entry leaves. halted=1 and out_valid=0 the following cycle.
- HALTED is left only by rst. Inputs are ignored in HALTED.
- ecall and illegal entries do not change state; EX/trap logic handles them.

Flush:
- Next cycle: out_valid=0, skid empty.
- A same-cycle accept is discarded (flush wins).
- HALT_PEND→RUN.
- Ignored in HALTED.

Reset mid-transfer: all held entries are dropped; no partial state is retained.

Decomposition:
Package ysyx_22050243_pkg holds:
- opcode localparams;
- ctrl_t packed struct (14 bits, field order as out_ctrl);
- mem2reg codes: ALU, MEM, IMM, PC4, PCIMM, CSR;
- pc_src codes;
- alu_op codes;
- exc_t {illegal, ecall, ebreak}.

Sub-module ysyx_22050243_inst_dec: pure combinational, in_inst → ctrl_t + exc_t, parameter XLEN.
The stage instantiates it once on the input side and registers its result.

Test Plan:
1. Reset, then stream addi 0x00500093, lw 0x0000A103, beq 0x00208463 with out_ready=1 → one out entry per cycle at latency 1; ctrl = 0_1_000_1_..._011, 0_1_001_1_1_..._000, ..._1_00_001.
2. Backpressure: out_ready=0 while 3 instructions are offered → 2 accepted (out + skid), in_ready=0 on the third; release out_ready → FIFO order preserved, no loss or duplication.
3. ebreak 0x00100073 followed by addi → addi not accepted; after ebreak retires, halted=1, out_valid=0; in_valid ignored for 10 cycles.
4. Decode checks: 0x00000000 → out_exc=100; ecall 0x00000073 → 010; csrrw 0x30529073 → ctrl 1_0_101_1_0_0_0_00_000; with XLEN=32, addiw 0x0010009B → illegal.
5. Flush with out + skid full and a same-cycle in_valid → next cycle out_valid=0, in_ready=1; the flushed word never appears on out.
6. rst asserted during HALT_PEND with 2 entries held → next cycle all outputs zero, halted=0, in_ready=1 after rst drops.
